// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
package rf_ctrl_pkg;

  // Default geometry of the 32x32 dual-read register file.
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
  localparam int DEF_DATA_W   = 32;

  // Per-requester operation encoding.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: grant is combinational from req and the
// pointer; the pointer moves to the loser whenever a grant is taken.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_r;

  // One-hot grant: a lone request always wins, a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer update: after a taken grant the other requester gets priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr_r <= gnt[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Sequencer and two-requester arbiter in front of the dual-read register
// file. Owns all register-file strobes/addresses/data, runs a zero-fill
// sweep after reset, then serialises one transaction per two cycles.
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int  NUM_REGS     = DEF_NUM_REGS,
  parameter int  DATA_W       = DEF_DATA_W,
  parameter bit  R0_HARDWIRED = 1'b1,
  parameter bit  INIT_CLEAR   = 1'b1,
  localparam int ADDR_W       = $clog2(NUM_REGS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          REQ,
  input  logic [1:0]          OP,
  input  logic [2*ADDR_W-1:0] ADDR_A,
  input  logic [2*ADDR_W-1:0] ADDR_B,
  input  logic [2*DATA_W-1:0] WDATA,
  output logic [1:0]          ACK,
  output logic [DATA_W-1:0]   RD_A,
  output logic [DATA_W-1:0]   RD_B,
  output logic                RD_VALID,
  output logic                RD_ID,
  output logic                INIT_DONE,
  output logic                RF_READ,
  output logic                RF_WRITE,
  output logic [ADDR_W-1:0]   RF_ADDR_R1,
  output logic [ADDR_W-1:0]   RF_ADDR_R2,
  output logic [ADDR_W-1:0]   RF_ADDR_W,
  output logic [DATA_W-1:0]   RF_DATA_W,
  input  logic [DATA_W-1:0]   RF_DATA_R1,
  input  logic [DATA_W-1:0]   RF_DATA_R2
);

  state_e              state_r;
  logic [ADDR_W-1:0]   init_cnt_r;
  logic                op_r;
  logic [ADDR_W-1:0]   addr_a_r;
  logic [ADDR_W-1:0]   addr_b_r;
  logic                win_id_r;

  logic [1:0]          gnt_s;
  logic                advance_s;
  logic                win_id_s;
  logic                sel_op_s;
  logic [ADDR_W-1:0]   sel_a_s;
  logic [ADDR_W-1:0]   sel_b_s;
  logic [DATA_W-1:0]   sel_wdata_s;

  // Arbitration only happens from IDLE, so REQ during INIT/ACCESS is ignored.
  assign advance_s = (state_r == ST_IDLE) && (REQ != 2'b00);

  rr_arbiter_2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .req     (REQ),
    .advance (advance_s),
    .gnt     (gnt_s)
  );

  // Route the winning requester's transaction fields.
  always_comb begin
    win_id_s    = 1'b0;
    sel_op_s    = OP_READ;
    sel_a_s     = '0;
    sel_b_s     = '0;
    sel_wdata_s = '0;
    if (gnt_s[1]) begin
      win_id_s    = 1'b1;
      sel_op_s    = OP[1];
      sel_a_s     = ADDR_A[2*ADDR_W-1:ADDR_W];
      sel_b_s     = ADDR_B[2*ADDR_W-1:ADDR_W];
      sel_wdata_s = WDATA[2*DATA_W-1:DATA_W];
    end else begin
      win_id_s    = 1'b0;
      sel_op_s    = OP[0];
      sel_a_s     = ADDR_A[ADDR_W-1:0];
      sel_b_s     = ADDR_B[ADDR_W-1:0];
      sel_wdata_s = WDATA[DATA_W-1:0];
    end
  end

  // Main sequencer: every output is registered and describes the action of
  // the state being entered, so strobes line up with the ACCESS cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= INIT_CLEAR ? ST_INIT : ST_IDLE;
      init_cnt_r <= '0;
      op_r       <= OP_READ;
      addr_a_r   <= '0;
      addr_b_r   <= '0;
      win_id_r   <= 1'b0;
      ACK        <= 2'b00;
      RD_A       <= '0;
      RD_B       <= '0;
      RD_VALID   <= 1'b0;
      RD_ID      <= 1'b0;
      INIT_DONE  <= 1'b0;
      RF_READ    <= 1'b0;
      RF_WRITE   <= 1'b0;
      RF_ADDR_R1 <= '0;
      RF_ADDR_R2 <= '0;
      RF_ADDR_W  <= '0;
      RF_DATA_W  <= '0;
    end else begin
      // Pulses default low; only the branches below raise them.
      ACK      <= 2'b00;
      RD_VALID <= 1'b0;
      RF_READ  <= 1'b0;
      RF_WRITE <= 1'b0;
      case (state_r)
        ST_INIT: begin
          RF_WRITE  <= 1'b1;
          RF_ADDR_W <= init_cnt_r;
          RF_DATA_W <= '0;
          if (init_cnt_r == ADDR_W'(NUM_REGS - 1)) begin
            state_r   <= ST_IDLE;
            INIT_DONE <= 1'b1;
          end else begin
            init_cnt_r <= init_cnt_r + 1'b1;
          end
        end
        ST_IDLE: begin
          // Covers INIT_CLEAR = 0, where no sweep ever raises the flag.
          INIT_DONE <= 1'b1;
          if (REQ != 2'b00) begin
            state_r  <= ST_ACCESS;
            ACK      <= gnt_s;
            win_id_r <= win_id_s;
            op_r     <= sel_op_s;
            addr_a_r <= sel_a_s;
            addr_b_r <= sel_b_s;
            if (sel_op_s == OP_READ) begin
              RF_READ    <= 1'b1;
              RF_ADDR_R1 <= sel_a_s;
              RF_ADDR_R2 <= sel_b_s;
            end else begin
              RF_ADDR_W <= sel_a_s;
              RF_DATA_W <= sel_wdata_s;
              // A hardwired r0 swallows the write but the requester is still acked.
              RF_WRITE  <= !(R0_HARDWIRED && (sel_a_s == '0));
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r <= ST_IDLE;
          if (op_r == OP_READ) begin
            RD_VALID <= 1'b1;
            RD_ID    <= win_id_r;
            RD_A     <= (R0_HARDWIRED && (addr_a_r == '0)) ? '0 : RF_DATA_R1;
            RD_B     <= (R0_HARDWIRED && (addr_b_r == '0)) ? '0 : RF_DATA_R2;
          end else begin
            RD_VALID <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a behavioural 32x32 register file.
module tb_rf_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req;
  logic [1:0]  op;
  logic [9:0]  addr_a;
  logic [9:0]  addr_b;
  logic [63:0] wdata;
  logic [1:0]  ack;
  logic [31:0] rd_a, rd_b;
  logic        rd_valid, rd_id, init_done;
  logic        rf_read, rf_write;
  logic [4:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
  logic [31:0] rf_data_w, rf_data_r1, rf_data_r2;
  logic        poison0;

  int n_tests = 0;
  int n_fail  = 0;

  rf_access_ctrl #(
    .NUM_REGS(32), .DATA_W(32), .R0_HARDWIRED(1'b1), .INIT_CLEAR(1'b1)
  ) dut (
    .CLK(clk), .RST(rst), .REQ(req), .OP(op), .ADDR_A(addr_a), .ADDR_B(addr_b),
    .WDATA(wdata), .ACK(ack), .RD_A(rd_a), .RD_B(rd_b), .RD_VALID(rd_valid),
    .RD_ID(rd_id), .INIT_DONE(init_done), .RF_READ(rf_read), .RF_WRITE(rf_write),
    .RF_ADDR_R1(rf_addr_r1), .RF_ADDR_R2(rf_addr_r2), .RF_ADDR_W(rf_addr_w),
    .RF_DATA_W(rf_data_w), .RF_DATA_R1(rf_data_r1), .RF_DATA_R2(rf_data_r2)
  );

  // Register file model; r0 is not hardwired here so the controller must mask it.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_addr_w] <= rf_data_w;
  end
  assign rf_data_r1 = (poison0 && rf_addr_r1 == 5'd0) ? 32'hBAD0BAD0 : rf_mem[rf_addr_r1];
  assign rf_data_r2 = (poison0 && rf_addr_r2 == 5'd0) ? 32'hBAD0BAD0 : rf_mem[rf_addr_r2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge, check per-cycle invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("rd_wr_excl", 64'(rf_read & rf_write), 64'd0);
    chk("ack_wo_req", 64'(ack & ~req), 64'd0);
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] o, input logic [9:0] a,
                       input logic [9:0] b, input logic [63:0] w);
    req = r; op = o; addr_a = a; addr_b = b; wdata = w;
  endtask

  initial begin
    int nz;
    logic exp_id;
    rst = 1'b1; poison0 = 1'b1;
    drive(2'b00, 2'b00, 10'd0, 10'd0, 64'd0);
    tick();
    tick();
    chk("rst_ack",      64'(ack),       64'd0);
    chk("rst_done",     64'(init_done), 64'd0);
    chk("rst_we",       64'(rf_write),  64'd0);
    chk("rst_re",       64'(rf_read),   64'd0);
    chk("rst_rdv",      64'(rd_valid),  64'd0);
    chk("rst_addr_w",   64'(rf_addr_w), 64'd0);

    // Requester 1 holds a write to r7 through the whole sweep.
    rst = 1'b0;
    drive(2'b10, 2'b10, {5'd7, 5'd0}, 10'd0, {32'h0000_0077, 32'h0});
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("init_we",    64'(rf_write),  64'd1);
      chk("init_addr",  64'(rf_addr_w), 64'(i));
      chk("init_data",  64'(rf_data_w), 64'd0);
      chk("init_noack", 64'(ack),       64'd0);
      chk("init_done",  64'(init_done), (i == 31) ? 64'd1 : 64'd0);
    end
    tick();
    chk("r1_ack",   64'(ack),       64'd2);
    chk("r1_we",    64'(rf_write),  64'd1);
    chk("r1_addr",  64'(rf_addr_w), 64'd7);
    chk("r1_data",  64'(rf_data_w), 64'h77);
    tick();
    chk("r1_ack_end", 64'(ack),      64'd0);
    chk("r1_we_end",  64'(rf_write), 64'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      if (i != 7 && rf_mem[i] !== 32'd0) nz++;
    end
    chk("sweep_zero", 64'(nz), 64'd0);
    chk("r7_commit",  64'(rf_mem[7]), 64'h77);

    // Requester 0: write 0xDEADBEEF to r5, then read A=5, B=0.
    drive(2'b01, 2'b01, {5'd0, 5'd5}, 10'd0, {32'h0, 32'hDEADBEEF});
    tick();
    chk("w5_ack",  64'(ack),       64'd1);
    chk("w5_we",   64'(rf_write),  64'd1);
    chk("w5_addr", 64'(rf_addr_w), 64'd5);
    chk("w5_data", 64'(rf_data_w), 64'hDEADBEEF);
    tick();
    chk("w5_ack_end", 64'(ack), 64'd0);
    drive(2'b01, 2'b00, {5'd0, 5'd5}, {5'd0, 5'd0}, 64'd0);
    tick();
    chk("r5_ack",   64'(ack),        64'd1);
    chk("r5_re",    64'(rf_read),    64'd1);
    chk("r5_ar1",   64'(rf_addr_r1), 64'd5);
    chk("r5_ar2",   64'(rf_addr_r2), 64'd0);
    chk("r5_norv",  64'(rd_valid),   64'd0);
    tick();
    chk("r5_rdv",   64'(rd_valid), 64'd1);
    chk("r5_rda",   64'(rd_a),     64'hDEADBEEF);
    chk("r5_rdb0",  64'(rd_b),     64'd0);
    chk("r5_id",    64'(rd_id),    64'd0);
    chk("r5_noack", 64'(ack),      64'd0);

    // Both requesters read continuously; pointer currently favours requester 1.
    drive(2'b11, 2'b00, {5'd7, 5'd5}, {5'd5, 5'd7}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      chk("rr_ack", 64'(ack), exp_id ? 64'd2 : 64'd1);
      tick();
      chk("rr_gap", 64'(ack),      64'd0);
      chk("rr_rdv", 64'(rd_valid), 64'd1);
      chk("rr_id",  64'(rd_id),    64'(exp_id));
      chk("rr_rda", 64'(rd_a),     exp_id ? 64'h77 : 64'hDEADBEEF);
      chk("rr_rdb", 64'(rd_b),     exp_id ? 64'hDEADBEEF : 64'h77);
    end

    // Write to hardwired r0 is acked but never strobed; reading it gives 0.
    drive(2'b01, 2'b01, 10'd0, 10'd0, {32'h0, 32'h0000_1234});
    tick();
    chk("w0_ack",  64'(ack),      64'd1);
    chk("w0_nowe", 64'(rf_write), 64'd0);
    tick();
    chk("w0_mem",  64'(rf_mem[0]), 64'd0);
    drive(2'b01, 2'b00, 10'd0, {5'd0, 5'd5}, 64'd0);
    tick();
    chk("r0_ack", 64'(ack),        64'd1);
    chk("r0_ar1", 64'(rf_addr_r1), 64'd0);
    tick();
    chk("r0_rdv", 64'(rd_valid), 64'd1);
    chk("r0_rda", 64'(rd_a),     64'd0);
    chk("r0_rdb", 64'(rd_b),     64'hDEADBEEF);

    // Reset lands during a read's ACCESS cycle.
    drive(2'b01, 2'b00, {5'd0, 5'd7}, {5'd0, 5'd5}, 64'd0);
    tick();
    chk("mid_ack", 64'(ack),     64'd1);
    chk("mid_re",  64'(rf_read), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_ack",  64'(ack),        64'd0);
    chk("mid_rst_rdv",  64'(rd_valid),   64'd0);
    chk("mid_rst_re",   64'(rf_read),    64'd0);
    chk("mid_rst_we",   64'(rf_write),   64'd0);
    chk("mid_rst_done", 64'(init_done),  64'd0);
    chk("mid_rst_rda",  64'(rd_a),       64'd0);
    chk("mid_rst_rdb",  64'(rd_b),       64'd0);
    chk("mid_rst_ar1",  64'(rf_addr_r1), 64'd0);
    rst = 1'b0;
    drive(2'b00, 2'b00, 10'd0, 10'd0, 64'd0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("reinit_rdv",  64'(rd_valid),  64'd0);
      chk("reinit_we",   64'(rf_write),  64'd1);
      chk("reinit_addr", 64'(rf_addr_w), 64'(i));
      chk("reinit_done", 64'(init_done), (i == 31) ? 64'd1 : 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
